// File: rtl/rtl_settings_pkg.sv
// Shared settings for the read-burst scheduler: AMM widths and the compare descriptor.
package rtl_settings_pkg;

    localparam int unsigned AMM_ADDR_W  = 32;
    localparam int unsigned AMM_BURST_W = 11;
    localparam int unsigned CMP_WC_W    = AMM_BURST_W - 1;
    localparam int unsigned CMP_OFS_W   = 2;
    localparam int unsigned CMP_PTRN_W  = 32;

    typedef enum logic [1:0] {
        DM_FIXED = 2'd0,
        DM_INCR  = 2'd1,
        DM_WALK1 = 2'd2,
        DM_LFSR  = 2'd3
    } data_mode_e;

    typedef struct packed {
        logic [AMM_ADDR_W-1:0] start_addr;
        logic [CMP_WC_W-1:0]   words_count;
        logic [CMP_OFS_W-1:0]  start_offset;
        logic [CMP_OFS_W-1:0]  end_offset;
        logic [CMP_PTRN_W-1:0] data_ptrn;
        data_mode_e            data_mode;
    } cmp_struct_t;

    localparam int unsigned CMP_STRUCT_W = $bits(cmp_struct_t);

    // words_count holds burst length minus one
    function automatic logic [AMM_BURST_W-1:0] burst_len(input logic [CMP_WC_W-1:0] wc);
        return AMM_BURST_W'(wc) + AMM_BURST_W'(1);
    endfunction

endpackage

// File: rtl/fifo.sv
// Show-ahead FIFO with synchronous clear; head word is visible on rdata_o while not empty.
module fifo #(
    parameter int unsigned DWIDTH = 8,
    parameter int unsigned AWIDTH = 2
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              clr_i,
    input  logic              wr_i,
    input  logic [DWIDTH-1:0] wdata_i,
    input  logic              rd_i,
    output logic [DWIDTH-1:0] rdata_o,
    output logic              empty_o
);

    localparam int unsigned DEPTH = 2 ** AWIDTH;
    localparam int unsigned CW    = AWIDTH + 1;

    logic [DWIDTH-1:0] mem_q [DEPTH];
    logic [AWIDTH-1:0] wptr_q, rptr_q;
    logic [CW-1:0]     cnt_q;
    logic              do_wr_c, do_rd_c;

    assign do_wr_c = wr_i && (cnt_q != CW'(DEPTH));
    assign do_rd_c = rd_i && (cnt_q != '0);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else if (clr_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_wr_c) wptr_q <= wptr_q + AWIDTH'(1);
            if (do_rd_c) rptr_q <= rptr_q + AWIDTH'(1);
            cnt_q <= cnt_q + CW'(do_wr_c) - CW'(do_rd_c);
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk_i) begin
        if (do_wr_c) mem_q[wptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rptr_q];
    assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/rd_burst_sched.sv
// Issues AMM read bursts under burst/beat credit limits and pushes one compare descriptor per burst.
module rd_burst_sched
    import rtl_settings_pkg::*;
#(
    parameter int unsigned MAX_BURSTS = 4,
    parameter int unsigned MAX_BEATS  = 64
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    test_start_i,
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic [CMP_STRUCT_W-1:0] cmd_struct_i,
    input  logic                    cmd_last_i,
    output logic                    read_o,
    output logic [AMM_ADDR_W-1:0]   address_o,
    output logic [AMM_BURST_W-1:0]  burstcount_o,
    input  logic                    waitrequest_i,
    input  logic                    readdatavalid_i,
    output logic                    cmp_en_o,
    output logic [CMP_STRUCT_W-1:0] cmp_struct_o,
    input  logic                    cmp_error_i,
    input  logic                    cmp_busy_i,
    output logic                    done_o,
    output logic                    abort_o
);

    localparam int unsigned BEAT_W = $clog2(MAX_BEATS + 1);
    localparam int unsigned BCNT_W = $clog2(MAX_BURSTS + 1);
    localparam int unsigned QAW    = (MAX_BURSTS > 1) ? $clog2(MAX_BURSTS) : 1;
    localparam int unsigned SUM_W  = ((BEAT_W > AMM_BURST_W) ? BEAT_W : AMM_BURST_W) + 1;

    typedef enum logic [2:0] {
        IDLE_S  = 3'd0,
        ISSUE_S = 3'd1,
        DRAIN_S = 3'd2,
        DONE_S  = 3'd3,
        ABORT_S = 3'd4
    } state_e;

    state_e                 state_q, state_d;
    logic                   last_q, last_d;
    logic                   read_q, read_d;
    logic [AMM_ADDR_W-1:0]  addr_q, addr_d;
    logic [AMM_BURST_W-1:0] bcnt_q, bcnt_d;
    logic                   cmp_en_q, cmp_en_d;
    cmp_struct_t            cmp_struct_q, cmp_struct_d;
    logic                   done_q, done_d;
    logic                   abort_q, abort_d;
    logic [BEAT_W-1:0]      beats_q, beats_d;
    logic [BCNT_W-1:0]      bursts_q, bursts_d;
    logic [CMP_WC_W-1:0]    rem_q, rem_d;
    logic                   rem_vld_q, rem_vld_d;

    cmp_struct_t            cmd_c;
    logic                   credit_ok_c, accept_c, req_done_c, beat_c, burst_end_c;
    logic [CMP_WC_W-1:0]    q_head_c, remaining_c;
    logic                   q_empty_c;

    assign cmd_c       = cmp_struct_t'(cmd_struct_i);
    assign credit_ok_c = (bursts_q < BCNT_W'(MAX_BURSTS)) &&
                         ((SUM_W'(beats_q) + SUM_W'(cmd_c.words_count) + SUM_W'(1)) <= SUM_W'(MAX_BEATS));
    // A request still held by waitrequest blocks new commands, even after a flush or abort.
    assign accept_c    = (state_q == IDLE_S) && cmd_valid_i && credit_ok_c && !read_q &&
                         !cmp_error_i && !test_start_i;
    assign cmd_ready_o = accept_c && rst_n_i;

    assign req_done_c  = read_q && !waitrequest_i;
    assign beat_c      = readdatavalid_i && (beats_q != '0) && !q_empty_c;
    assign remaining_c = rem_vld_q ? rem_q : q_head_c;
    assign burst_end_c = beat_c && (remaining_c == '0);

    // Lengths (minus one) of bursts in flight, oldest at the head.
    fifo #(
        .DWIDTH (CMP_WC_W),
        .AWIDTH (QAW)
    ) u_len_q (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .clr_i   (test_start_i),
        .wr_i    (accept_c),
        .wdata_i (cmd_c.words_count),
        .rd_i    (burst_end_c),
        .rdata_o (q_head_c),
        .empty_o (q_empty_c)
    );

    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        read_d       = read_q;
        addr_d       = addr_q;
        bcnt_d       = bcnt_q;
        cmp_en_d     = 1'b0;
        cmp_struct_d = cmp_struct_q;
        beats_d      = beats_q;
        bursts_d     = bursts_q;
        rem_d        = rem_q;
        rem_vld_d    = rem_vld_q;

        if (req_done_c) read_d = 1'b0;

        if (beat_c) begin
            beats_d = beats_q - BEAT_W'(1);
            if (remaining_c == '0) begin
                rem_vld_d = 1'b0;
                bursts_d  = bursts_q - BCNT_W'(1);
            end else begin
                rem_d     = remaining_c - CMP_WC_W'(1);
                rem_vld_d = 1'b1;
            end
        end

        if (accept_c) begin
            beats_d      = BEAT_W'(SUM_W'(beats_d) + SUM_W'(cmd_c.words_count) + SUM_W'(1));
            bursts_d     = bursts_d + BCNT_W'(1);
            read_d       = 1'b1;
            addr_d       = cmd_c.start_addr;
            bcnt_d       = burst_len(cmd_c.words_count);
            cmp_en_d     = 1'b1;
            cmp_struct_d = cmd_c;
            last_d       = cmd_last_i;
        end

        case (state_q)
            IDLE_S:  if (accept_c) state_d = ISSUE_S;
            ISSUE_S: if (req_done_c) state_d = last_q ? DRAIN_S : IDLE_S;
            DRAIN_S: if ((beats_q == '0) && (bursts_q == '0) && !cmp_busy_i) state_d = DONE_S;
            DONE_S:  state_d = DONE_S;
            ABORT_S: state_d = ABORT_S;
            default: state_d = IDLE_S;
        endcase

        if (cmp_error_i && (state_q != DONE_S)) state_d = ABORT_S;

        if (test_start_i) begin
            state_d   = IDLE_S;
            beats_d   = '0;
            bursts_d  = '0;
            rem_d     = '0;
            rem_vld_d = 1'b0;
        end

        done_d  = (state_d == DONE_S);
        abort_d = (state_d == ABORT_S);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= IDLE_S;
            last_q       <= 1'b0;
            read_q       <= 1'b0;
            addr_q       <= '0;
            bcnt_q       <= '0;
            cmp_en_q     <= 1'b0;
            cmp_struct_q <= '0;
            done_q       <= 1'b0;
            abort_q      <= 1'b0;
            beats_q      <= '0;
            bursts_q     <= '0;
            rem_q        <= '0;
            rem_vld_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            read_q       <= read_d;
            addr_q       <= addr_d;
            bcnt_q       <= bcnt_d;
            cmp_en_q     <= cmp_en_d;
            cmp_struct_q <= cmp_struct_d;
            done_q       <= done_d;
            abort_q      <= abort_d;
            beats_q      <= beats_d;
            bursts_q     <= bursts_d;
            rem_q        <= rem_d;
            rem_vld_q    <= rem_vld_d;
        end
    end

    assign read_o       = read_q;
    assign address_o    = addr_q;
    assign burstcount_o = bcnt_q;
    assign cmp_en_o     = cmp_en_q;
    assign cmp_struct_o = cmp_struct_q;
    assign done_o       = done_q;
    assign abort_o      = abort_q;

endmodule

// File: tb/tb_rd_burst_sched.sv
// Directed bench for rd_burst_sched: vector table of single-command tests plus credit, abort and reset sequences.
module tb_rd_burst_sched;
    import rtl_settings_pkg::*;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    test_start;
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic [CMP_STRUCT_W-1:0] cmd_struct;
    logic                    cmd_last;
    logic                    read_o;
    logic [AMM_ADDR_W-1:0]   address;
    logic [AMM_BURST_W-1:0]  burstcount;
    logic                    waitreq;
    logic                    rdv;
    logic                    cmp_en;
    logic [CMP_STRUCT_W-1:0] cmp_struct;
    logic                    cmp_error;
    logic                    cmp_busy;
    logic                    done;
    logic                    abort;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rd_burst_sched #(.MAX_BURSTS(4), .MAX_BEATS(64)) dut (
        .clk_i           (clk),
        .rst_n_i         (rst_n),
        .test_start_i    (test_start),
        .cmd_valid_i     (cmd_valid),
        .cmd_ready_o     (cmd_ready),
        .cmd_struct_i    (cmd_struct),
        .cmd_last_i      (cmd_last),
        .read_o          (read_o),
        .address_o       (address),
        .burstcount_o    (burstcount),
        .waitrequest_i   (waitreq),
        .readdatavalid_i (rdv),
        .cmp_en_o        (cmp_en),
        .cmp_struct_o    (cmp_struct),
        .cmp_error_i     (cmp_error),
        .cmp_busy_i      (cmp_busy),
        .done_o          (done),
        .abort_o         (abort)
    );

    typedef struct {
        logic [AMM_ADDR_W-1:0]  addr;
        logic [CMP_WC_W-1:0]    wc;
        int                     stall;
        logic [AMM_BURST_W-1:0] exp_bc;
        int                     exp_rd_cycles;
    } vec_t;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic cmp_struct_t mk_cmd(input logic [AMM_ADDR_W-1:0] a, input logic [CMP_WC_W-1:0] wc);
        cmp_struct_t c;
        c.start_addr   = a;
        c.words_count  = wc;
        c.start_offset = 2'd1;
        c.end_offset   = 2'd2;
        c.data_ptrn    = 32'hA5A5_0000 ^ a;
        c.data_mode    = DM_INCR;
        return c;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic pulse_start();
        tick();
        test_start = 1'b1;
        tick();
        test_start = 1'b0;
    endtask

    task automatic send_beats(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            rdv = 1'b1;
        end
        tick();
        rdv = 1'b0;
    endtask

    // Presents a command until accepted (bounded); returns at the negedge after the accepting edge.
    task automatic issue_cmd(input cmp_struct_t c, input logic last, output logic ok);
        tick();
        cmd_valid  = 1'b1;
        cmd_struct = c;
        cmd_last   = last;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        tick();
        cmd_valid = 1'b0;
        cmd_last  = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t        vecs[4];
        logic        ok;
        int          rc, ec, acc, rd_cnt, rdy_cnt, addr_bad;
        logic [AMM_BURST_W-1:0] bc_seen;
        cmp_struct_t st_seen;

        vecs[0] = '{addr: 32'h0000_1000, wc: 10'd3,  stall: 0, exp_bc: 11'd4,  exp_rd_cycles: 1};
        vecs[1] = '{addr: 32'h0000_2000, wc: 10'd0,  stall: 0, exp_bc: 11'd1,  exp_rd_cycles: 1};
        vecs[2] = '{addr: 32'h0000_3000, wc: 10'd3,  stall: 5, exp_bc: 11'd4,  exp_rd_cycles: 6};
        vecs[3] = '{addr: 32'h0000_4000, wc: 10'd63, stall: 2, exp_bc: 11'd64, exp_rd_cycles: 3};

        rst_n      = 1'b0;
        test_start = 1'b0;
        cmd_valid  = 1'b1;
        cmd_struct = mk_cmd(32'h0000_0100, 10'd0);
        cmd_last   = 1'b0;
        waitreq    = 1'b0;
        rdv        = 1'b0;
        cmp_error  = 1'b0;
        cmp_busy   = 1'b0;

        #12;
        chk("rst_read", read_o, 1'b0);
        chk("rst_ready", cmd_ready, 1'b0);
        chk("rst_cmp_en", cmp_en, 1'b0);
        chk("rst_done_abort", {done, abort}, 2'b00);
        chk("rst_addr_bc", {address, burstcount}, '0);
        tick();
        cmd_valid = 1'b0;
        rst_n     = 1'b1;

        // Single-command vectors: request timing, descriptor push, completion.
        foreach (vecs[v]) begin
            pulse_start();
            tick();
            cmd_valid  = 1'b1;
            cmd_struct = mk_cmd(vecs[v].addr, vecs[v].wc);
            cmd_last   = 1'b1;
            cmp_busy   = 1'b1;
            #1;
            chk($sformatf("v%0d_ready", v), cmd_ready, 1'b1);
            rc = 0; ec = 0; addr_bad = 0; bc_seen = '0; st_seen = '0;
            for (int k = 0; k < vecs[v].stall + 4; k++) begin
                tick();
                cmd_valid = 1'b0;
                cmd_last  = 1'b0;
                waitreq   = (k < vecs[v].stall);
                #1;
                if (read_o) begin
                    rc++;
                    if (address !== vecs[v].addr) addr_bad++;
                end
                if (cmp_en) begin
                    ec++;
                    st_seen = cmp_struct_t'(cmp_struct);
                end
                if (k == 0) bc_seen = burstcount;
            end
            waitreq = 1'b0;
            chk($sformatf("v%0d_read_cycles", v), rc, vecs[v].exp_rd_cycles);
            chk($sformatf("v%0d_cmp_en_cnt", v), ec, 1);
            chk($sformatf("v%0d_burstcount", v), bc_seen, vecs[v].exp_bc);
            chk($sformatf("v%0d_addr_stable", v), addr_bad, 0);
            chk($sformatf("v%0d_cmp_struct", v), st_seen, mk_cmd(vecs[v].addr, vecs[v].wc));
            send_beats(int'(vecs[v].exp_bc));
            tick();
            #1;
            chk($sformatf("v%0d_done_busy", v), done, 1'b0);
            tick();
            cmp_busy = 1'b0;
            #1;
            chk($sformatf("v%0d_done_early", v), done, 1'b0);
            tick();
            #1;
            chk($sformatf("v%0d_done", v), done, 1'b1);
        end

        // Burst credit: 1-beat commands back to back, no read data returned.
        pulse_start();
        acc = 0;
        tick();
        cmd_valid  = 1'b1;
        cmd_struct = mk_cmd(32'h0000_5000, 10'd0);
        cmd_last   = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (cmd_ready) acc++;
            tick();
        end
        chk("a_accepts", acc, 4);
        rdv = 1'b1;
        #1;
        chk("a_ready_beat_cycle", cmd_ready, 1'b0);
        tick();
        rdv = 1'b0;
        #1;
        chk("a_ready_after_beat", cmd_ready, 1'b1);
        tick();
        cmd_valid = 1'b0;

        // Beat credit: 32+32 beats fill the window; 8-beat command waits for 8 returns.
        pulse_start();
        issue_cmd(mk_cmd(32'h0000_6000, 10'd31), 1'b0, ok);
        chk("b_issue1", ok, 1'b1);
        issue_cmd(mk_cmd(32'h0000_6400, 10'd31), 1'b0, ok);
        chk("b_issue2", ok, 1'b1);
        tick();
        cmd_valid  = 1'b1;
        cmd_struct = mk_cmd(32'h0000_7000, 10'd7);
        rdy_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (cmd_ready) rdy_cnt++;
            tick();
        end
        chk("b_stalled", rdy_cnt, 0);
        for (int i = 0; i < 8; i++) begin
            rdv = 1'b1;
            tick();
            rdv = 1'b0;
            #1;
            chk($sformatf("b_ready_after_beat%0d", i), cmd_ready, (i == 7));
            tick();
        end
        cmd_valid = 1'b0;

        // Comparator error mid-stream, then recovery via test_start.
        pulse_start();
        issue_cmd(mk_cmd(32'h0000_8000, 10'd3), 1'b0, ok);
        chk("c_issue", ok, 1'b1);
        tick();
        tick();
        cmd_valid  = 1'b1;
        cmd_struct = mk_cmd(32'h0000_9000, 10'd0);
        cmp_error  = 1'b1;
        #1;
        chk("c_ready_on_error", cmd_ready, 1'b0);
        tick();
        cmp_error = 1'b0;
        #1;
        chk("c_abort", abort, 1'b1);
        rd_cnt = 0;
        rdy_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            #1;
            if (read_o) rd_cnt++;
            if (cmd_ready) rdy_cnt++;
        end
        chk("c_no_read", rd_cnt, 0);
        chk("c_no_ready", rdy_cnt, 0);
        chk("c_abort_held", abort, 1'b1);
        cmd_valid = 1'b0;
        pulse_start();
        #1;
        chk("c_abort_cleared", {abort, done}, 2'b00);
        tick();
        cmd_valid  = 1'b1;
        cmd_struct = mk_cmd(32'h0000_A000, 10'd63);
        #1;
        chk("c_counters_cleared", cmd_ready, 1'b1);
        tick();
        cmd_valid = 1'b0;
        tick();

        // Error while the request is stalled: read_o held until accepted.
        pulse_start();
        waitreq = 1'b1;
        issue_cmd(mk_cmd(32'h0000_B000, 10'd1), 1'b0, ok);
        chk("c2_issue", ok, 1'b1);
        cmp_error = 1'b1;
        #1;
        chk("c2_read_pre", read_o, 1'b1);
        tick();
        cmp_error = 1'b0;
        #1;
        chk("c2_abort", abort, 1'b1);
        chk("c2_read_hold", {read_o, address}, {1'b1, 32'h0000_B000});
        tick();
        waitreq = 1'b0;
        #1;
        chk("c2_read_still", read_o, 1'b1);
        tick();
        #1;
        chk("c2_read_drop", read_o, 1'b0);

        // Asynchronous reset in the middle of a stalled request.
        pulse_start();
        waitreq = 1'b1;
        issue_cmd(mk_cmd(32'h0000_C000, 10'd2), 1'b0, ok);
        chk("d_issue", ok, 1'b1);
        cmd_valid  = 1'b1;
        cmd_struct = mk_cmd(32'h0000_D000, 10'd0);
        #1;
        chk("d_read_pre", read_o, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("d_read", read_o, 1'b0);
        chk("d_addr_bc", {address, burstcount}, '0);
        chk("d_cmp_struct", cmp_struct, '0);
        chk("d_flags", {cmd_ready, cmp_en, done, abort}, 4'b0000);
        tick();
        tick();
        rst_n     = 1'b1;
        waitreq   = 1'b0;
        cmd_valid = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
